// File: rtl/bus_transfer_ctrl_pkg.sv
// bus_transfer_ctrl_pkg: shared code constants and state type for the bus transfer controller
// Source codes follow the bus encoder bit order; destination codes follow the dst_in bit order.
package bus_transfer_ctrl_pkg;
  localparam int NUM_CODES = 24;
  localparam logic [4:0] SRC_R0 = 5'd0;
  localparam logic [4:0] SRC_R15 = 5'd15;
  localparam logic [4:0] SRC_HI = 5'd16;
  localparam logic [4:0] SRC_LO = 5'd17;
  localparam logic [4:0] SRC_ZHI = 5'd18;
  localparam logic [4:0] SRC_ZLO = 5'd19;
  localparam logic [4:0] SRC_PC = 5'd20;
  localparam logic [4:0] SRC_MDR = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_C = 5'd23;
  localparam logic [4:0] DST_R0 = 5'd0;
  localparam logic [4:0] DST_R15 = 5'd15;
  localparam logic [4:0] DST_HI = 5'd16;
  localparam logic [4:0] DST_LO = 5'd17;
  localparam logic [4:0] DST_PC = 5'd18;
  localparam logic [4:0] DST_MDR = 5'd19;
  localparam logic [4:0] DST_MAR = 5'd20;
  localparam logic [4:0] DST_IR = 5'd21;
  localparam logic [4:0] DST_Y = 5'd22;
  localparam logic [4:0] DST_OUTPORT = 5'd23;
  typedef enum logic [2:0] {IDLE, DRIVE, LATCH, DONE, ERR} state_t;
endpackage

// File: rtl/bus_transfer_ctrl_onehot_decoder.sv
// onehot_decoder_5to24: 5-bit code to 24-bit one-hot, zero for codes >= 24
// Ports: code (5-bit code in), onehot (24-bit one-hot out).
module onehot_decoder_5to24 (
  input  logic [4:0]  code,
  output logic [23:0] onehot
);
  assign onehot = (code < 5'd24) ? 24'd1 << code : '0;
endmodule

// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl: sequences one register transfer (drive source, settle, load destination, ack)
// Ports: clock/clear (async active-high reset), xfer_req/src_sel/dst_sel request,
// src_out/dst_in one-hot drives, xfer_ack/xfer_err completion pulses, busy.
module bus_transfer_ctrl
  import bus_transfer_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_CODES = bus_transfer_ctrl_pkg::NUM_CODES
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        xfer_req,
  input  logic [4:0]  src_sel,
  input  logic [4:0]  dst_sel,
  output logic [23:0] src_out,
  output logic [23:0] dst_in,
  output logic        xfer_ack,
  output logic        xfer_err,
  output logic        busy
);
  state_t state;
  logic [4:0] dst_q;
  logic [3:0] cnt;
  logic [23:0] src_oh, dst_oh;
  logic ok;
  // The source one-hot is registered straight from the request, so src_out itself holds the captured source.
  onehot_decoder_5to24 u_src (.code(src_sel), .onehot(src_oh));
  onehot_decoder_5to24 u_dst (.code(dst_q), .onehot(dst_oh));
  assign ok = int'(src_sel) < NUM_CODES && int'(dst_sel) < NUM_CODES;
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      src_out <= '0;
      dst_in <= '0;
      xfer_ack <= 1'b0;
      xfer_err <= 1'b0;
      busy <= 1'b0;
      dst_q <= '0;
      cnt <= '0;
    end else begin
      xfer_ack <= 1'b0;
      xfer_err <= 1'b0;
      dst_in <= '0;
      case (state)
        IDLE: if (xfer_req) begin
          busy <= 1'b1;
          if (ok) begin
            state <= DRIVE;
            src_out <= src_oh;
            dst_q <= dst_sel;
            cnt <= 4'(SETTLE_CYCLES);
          end else begin
            state <= ERR;
            xfer_err <= 1'b1;
          end
        end
        DRIVE: if (cnt == 4'd1) begin
          state <= LATCH;
          dst_in <= dst_oh;
        end else cnt <= cnt - 4'd1;
        LATCH: begin
          state <= DONE;
          src_out <= '0;
          xfer_ack <= 1'b1;
        end
        DONE, ERR: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
